gpio_bank_ctrl: RTL and testbench
=================================

// Module: gpio_bank_ctrl
// PURPOSE
//  Multi-pin GPIO controller. Drives a bank of NUM_PINS generic digital GPIO pad cells
//  from the core register file and returns clean per-pin input state to it.
//  Per pin, it registers the output/enable controls, synchronises and debounces the pad
//  input, and raises sticky edge interrupts. It sits between the MMIO register block and
//  the pad ring; the pad cells themselves stay purely combinational.
// PARAMETERS
//  NUM_PINS     8  number of GPIO pins in the bank
//  SYNC_STAGES  2  synchroniser depth on pad input, >=2
//  FILT_WIDTH   4  width of debounce length field and per-pin counter
// PORTS
//  clock         in   1           core clock; all state on rising edge
//  reset         in   1           synchronous, active-high
//  cfg_out       in   NUM_PINS    output value per pin
//  cfg_oe        in   NUM_PINS    output enable per pin
//  cfg_ie        in   NUM_PINS    input enable per pin
//  cfg_filt_en   in   NUM_PINS    debounce enable per pin
//  cfg_filt_len  in   FILT_WIDTH  debounce length L in cycles, shared; 0 treated as 1
//  cfg_irq_rise  in   NUM_PINS    rising-edge interrupt enable
//  cfg_irq_fall  in   NUM_PINS    falling-edge interrupt enable
//  irq_clear     in   NUM_PINS    1-cycle clear pulse per pending bit
//  pad_in        in   NUM_PINS    raw input from pad cells (asynchronous)
//  cell_o        out  NUM_PINS    to pad cell o
//  cell_oe       out  NUM_PINS    to pad cell oe
//  cell_ie       out  NUM_PINS    to pad cell ie
//  pin_value     out  NUM_PINS    synchronised, filtered input state
//  irq_pending   out  NUM_PINS    sticky per-pin interrupt status
//  irq           out  1           OR-reduction of irq_pending
// BEHAVIOUR
//  Reset: cell_o, cell_oe, cell_ie, pin_value and irq_pending are 0. irq is 0.
//    Synchroniser flops, debounce counters and the edge-detect history are 0.
//    Reset asserted mid-debounce discards the partial count.
//  Output path: cell_o/cell_oe/cell_ie are registered copies of cfg_*. Latency is 1 cycle.
//    There is no gating between oe and o.
//  Sync: pad_in passes through SYNC_STAGES flops. Call the result s.
//  Debounce, per pin; the counter cnt is FILT_WIDTH bits:
//    If s == pin_value, cnt <= 0.
//    If s != pin_value and cnt == Leff-1, pin_value <= s and cnt <= 0.
//    Otherwise cnt <= cnt+1.
//    Leff = 1 when cfg_filt_en=0 or cfg_filt_len=0; otherwise Leff = cfg_filt_len.
//    Latency from a pad change to pin_value = SYNC_STAGES + Leff cycles.
//    A glitch shorter than Leff cycles after sync never reaches pin_value.
//    Changing cfg_filt_len mid-count uses the new value from the next cycle.
//    A count already >= the new Leff-1 updates pin_value on the next differing cycle.
//  Edge detect: prev <= pin_value every cycle.
//    rise = pin_value & ~prev; fall = ~pin_value & prev.
//  Pending: set when (rise & cfg_irq_rise) | (fall & cfg_irq_fall), and only while
//    cell_ie=1. Cleared by irq_clear.
//    If set and clear occur in the same cycle, set wins.
//    Pending bits are sticky; disabling the enable does not clear them.
//  irq: combinational OR of the irq_pending register. It goes high 1 cycle after the
//    edge appears on pin_value.
//  When ie=0 the pad cell returns 0, so pin_value decays to 0 through the filter.
//    That fall is not recorded while cell_ie=0.
// STRUCTURE
//  Package gpio_pkg holds:
//    - the SYNC_STAGES and FILT_WIDTH defaults
//    - the edge-select encoding for rise/fall enable bit positions
//  Sub-module gpio_pin_filter holds one pin's sync chain, debounce counter, edge detect
//  and pending bit. It is instantiated NUM_PINS times via generate.
//  The top level holds the output registers and the irq OR.
// TESTING
//  1. Reset, then cfg_oe=8'hA5, cfg_out=8'h0F.
//     -> cell_oe=A5 and cell_o=0F exactly 1 cycle later. Both are 0 during reset.
//  2. filt_en=0. pad_in[0] goes 0->1.
//     -> pin_value[0]=1 after 3 cycles (SYNC 2 + 1).
//     -> with rise enabled and ie=1, irq_pending[0] and irq are 1 one cycle after that.
//  3. filt_en[1]=1, filt_len=5, pad_in[1] high for 4 cycles -> pin_value[1] stays 0.
//     Then high for 5 cycles -> pin_value[1]=1 at cycle 7 after the edge.
//  4. Fall enabled on pin 2. In the same cycle that the fall edge sets pending, pulse
//     irq_clear[2].
//     -> pending stays 1. A lone clear on the next cycle -> pending 0, irq 0.
//  5. Pin 3 high, ie[3]=1, rise/fall enabled. Drop cfg_ie[3] to 0.
//     -> pin_value[3] falls, irq_pending[3] stays 0.
//  6. Assert reset mid-count with filt_len=8 after 4 differing cycles.
//     -> all outputs 0. A fresh full 8-cycle count is needed after release.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared defaults and edge-select bit positions for the GPIO bank controller.
package gpio_pkg;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int FILT_WIDTH_DEF  = 4;

    // Bit positions within a pin's two-bit edge-enable vector.
    localparam int EDGE_RISE_BIT = 0;
    localparam int EDGE_FALL_BIT = 1;
    localparam int EDGE_SEL_W    = 2;
endpackage

// File: rtl/gpio_pin_filter.sv
// One GPIO pin: input synchroniser, debounce counter, edge detect and sticky pending bit.
module gpio_pin_filter
    import gpio_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILT_WIDTH  = FILT_WIDTH_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_pad,
    input  logic                  i_filt_en,
    input  logic [FILT_WIDTH-1:0] i_filt_len,
    input  logic [EDGE_SEL_W-1:0] i_edge_en,
    input  logic                  i_ie,
    input  logic                  i_clear,
    output logic                  o_value,
    output logic                  o_pending
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic [FILT_WIDTH-1:0]  r_cnt;
    logic                   r_value;
    logic                   r_prev;
    logic                   r_pending;
    logic [FILT_WIDTH-1:0]  w_last;
    logic                   w_s;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_set;

    assign w_s = r_sync[SYNC_STAGES-1];

    // Terminal count is Leff-1; a zero length or disabled filter behaves as Leff=1.
    assign w_last = (i_filt_en && (i_filt_len != '0)) ? (i_filt_len - FILT_WIDTH'(1)) : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pad};
        end
    end

    // Using >= lets a shortened length take effect on the very next differing cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_value <= 1'b0;
        end else if (w_s == r_value) begin
            r_cnt <= '0;
        end else if (r_cnt >= w_last) begin
            r_value <= w_s;
            r_cnt   <= '0;
        end else begin
            r_cnt <= r_cnt + FILT_WIDTH'(1);
        end
    end

    assign w_rise = r_value & ~r_prev;
    assign w_fall = ~r_value & r_prev;
    assign w_set  = i_ie & ((w_rise & i_edge_en[EDGE_RISE_BIT]) |
                            (w_fall & i_edge_en[EDGE_FALL_BIT]));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prev    <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_prev    <= r_value;
            r_pending <= w_set | (r_pending & ~i_clear);
        end
    end

    assign o_value   = r_value;
    assign o_pending = r_pending;
endmodule

// File: rtl/gpio_bank_ctrl.sv
// GPIO bank: registered pad-cell controls, per-pin input filters and the bank interrupt.
module gpio_bank_ctrl
    import gpio_pkg::*;
#(
    parameter int NUM_PINS    = 8,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILT_WIDTH  = FILT_WIDTH_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_PINS-1:0]   cfg_out,
    input  logic [NUM_PINS-1:0]   cfg_oe,
    input  logic [NUM_PINS-1:0]   cfg_ie,
    input  logic [NUM_PINS-1:0]   cfg_filt_en,
    input  logic [FILT_WIDTH-1:0] cfg_filt_len,
    input  logic [NUM_PINS-1:0]   cfg_irq_rise,
    input  logic [NUM_PINS-1:0]   cfg_irq_fall,
    input  logic [NUM_PINS-1:0]   irq_clear,
    input  logic [NUM_PINS-1:0]   pad_in,
    output logic [NUM_PINS-1:0]   cell_o,
    output logic [NUM_PINS-1:0]   cell_oe,
    output logic [NUM_PINS-1:0]   cell_ie,
    output logic [NUM_PINS-1:0]   pin_value,
    output logic [NUM_PINS-1:0]   irq_pending,
    output logic                  irq
);
    logic [NUM_PINS-1:0] r_cell_o;
    logic [NUM_PINS-1:0] r_cell_oe;
    logic [NUM_PINS-1:0] r_cell_ie;
    logic [NUM_PINS-1:0] w_value;
    logic [NUM_PINS-1:0] w_pending;

    // o and oe are passed through independently; the pad cell resolves them.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cell_o  <= '0;
            r_cell_oe <= '0;
            r_cell_ie <= '0;
        end else begin
            r_cell_o  <= cfg_out;
            r_cell_oe <= cfg_oe;
            r_cell_ie <= cfg_ie;
        end
    end

    for (genvar g = 0; g < NUM_PINS; g++) begin : g_pin
        logic [EDGE_SEL_W-1:0] w_edge_en;

        always_comb begin
            w_edge_en                = '0;
            w_edge_en[EDGE_RISE_BIT] = cfg_irq_rise[g];
            w_edge_en[EDGE_FALL_BIT] = cfg_irq_fall[g];
        end

        gpio_pin_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_WIDTH  (FILT_WIDTH)
        ) u_pin (
            .i_clk      (clock),
            .i_rst      (reset),
            .i_pad      (pad_in[g]),
            .i_filt_en  (cfg_filt_en[g]),
            .i_filt_len (cfg_filt_len),
            .i_edge_en  (w_edge_en),
            .i_ie       (r_cell_ie[g]),
            .i_clear    (irq_clear[g]),
            .o_value    (w_value[g]),
            .o_pending  (w_pending[g])
        );
    end

    assign cell_o      = r_cell_o;
    assign cell_oe     = r_cell_oe;
    assign cell_ie     = r_cell_ie;
    assign pin_value   = w_value;
    assign irq_pending = w_pending;
    assign irq         = |w_pending;
endmodule

// File: tb/tb_gpio_bank_ctrl.sv
// Bench for gpio_bank_ctrl: directed pin scenarios against a cycle-level behavioural model.
module tb_gpio_bank_ctrl;
    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] cfg_out, cfg_oe, cfg_ie, cfg_filt_en;
    logic [3:0] cfg_filt_len;
    logic [7:0] cfg_irq_rise, cfg_irq_fall, irq_clear;
    logic [7:0] pad_raw;
    logic [7:0] pad_in;
    logic [7:0] cell_o, cell_oe, cell_ie, pin_value, irq_pending;
    logic       irq;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    // Pad cell: input buffer returns 0 while its ie is low.
    assign pad_in = pad_raw & cell_ie;

    gpio_bank_ctrl #(.NUM_PINS(8), .SYNC_STAGES(2), .FILT_WIDTH(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .cfg_out      (cfg_out),
        .cfg_oe       (cfg_oe),
        .cfg_ie       (cfg_ie),
        .cfg_filt_en  (cfg_filt_en),
        .cfg_filt_len (cfg_filt_len),
        .cfg_irq_rise (cfg_irq_rise),
        .cfg_irq_fall (cfg_irq_fall),
        .irq_clear    (irq_clear),
        .pad_in       (pad_in),
        .cell_o       (cell_o),
        .cell_oe      (cell_oe),
        .cell_ie      (cell_ie),
        .pin_value    (pin_value),
        .irq_pending  (irq_pending),
        .irq          (irq)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Behavioural model: pad samples age through a queue, a pin follows its input once the
    // input has disagreed for Leff consecutive cycles, edges are pin changes between cycles.
    logic [7:0] m_cell_o = '0, m_cell_oe = '0, m_cell_ie = '0;
    logic [7:0] m_pin = '0, m_last = '0, m_pend = '0;
    logic [7:0] m_hist[$];
    int         m_run[8];
    bit         m_valid = 1'b0;
    logic [7:0] m_s, m_new, m_set;
    int         m_leff;

    always @(posedge clock) begin
        if (reset) begin
            m_cell_o = '0; m_cell_oe = '0; m_cell_ie = '0;
            m_pin = '0; m_last = '0; m_pend = '0;
            m_hist = '{8'h00, 8'h00};
            for (int i = 0; i < 8; i++) m_run[i] = 0;
        end else begin
            m_s = m_hist[0];
            void'(m_hist.pop_front());
            m_hist.push_back(pad_raw & m_cell_ie);
            m_new = m_pin;
            for (int i = 0; i < 8; i++) begin
                m_leff = (cfg_filt_en[i] && cfg_filt_len != 0) ? int'(cfg_filt_len) : 1;
                if (m_s[i] == m_pin[i]) begin
                    m_run[i] = 0;
                end else begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] >= m_leff) begin
                        m_new[i] = m_s[i];
                        m_run[i] = 0;
                    end
                end
            end
            m_set  = m_cell_ie & (((m_pin & ~m_last) & cfg_irq_rise) |
                                  ((~m_pin & m_last) & cfg_irq_fall));
            m_pend = m_set | (m_pend & ~irq_clear);
            m_last = m_pin;
            m_pin  = m_new;
            m_cell_o = cfg_out; m_cell_oe = cfg_oe; m_cell_ie = cfg_ie;
        end
        m_valid = 1'b1;
    end

    always @(negedge clock) begin
        if (m_valid) begin
            check("cmp_cell_o", cell_o, m_cell_o);
            check("cmp_cell_oe", cell_oe, m_cell_oe);
            check("cmp_cell_ie", cell_ie, m_cell_ie);
            check("cmp_pin_value", pin_value, m_pin);
            check("cmp_irq_pending", irq_pending, m_pend);
            check("cmp_irq", {7'b0, irq}, {7'b0, |m_pend});
        end
    end

    initial begin
        reset = 1'b1;
        cfg_out = '0; cfg_oe = '0; cfg_ie = '0; cfg_filt_en = '0; cfg_filt_len = '0;
        cfg_irq_rise = '0; cfg_irq_fall = '0; irq_clear = '0; pad_raw = '0;
        tick(2);

        // Output registers: held at 0 in reset, 1-cycle latency after.
        cfg_oe = 8'hA5; cfg_out = 8'h0F;
        tick(1);
        check("rst_cell_oe", cell_oe, 8'h00);
        check("rst_cell_o", cell_o, 8'h00);
        check("rst_pin_value", pin_value, 8'h00);
        check("rst_irq_pending", irq_pending, 8'h00);
        reset = 1'b0;
        tick(1);
        check("cell_oe_a5", cell_oe, 8'hA5);
        check("cell_o_0f", cell_o, 8'h0F);

        // Unfiltered rise on pin 0: 3-cycle latency, pending one cycle later.
        cfg_ie = 8'hFF; cfg_irq_rise = 8'h01;
        tick(3);
        check("cell_ie_ff", cell_ie, 8'hFF);
        pad_raw[0] = 1'b1;
        tick(2);
        check("pin0_early", pin_value & 8'h01, 8'h00);
        tick(1);
        check("pin0_lat3", pin_value & 8'h01, 8'h01);
        check("pend0_not_yet", irq_pending & 8'h01, 8'h00);
        tick(1);
        check("pend0_set", irq_pending & 8'h01, 8'h01);
        check("irq_set", {7'b0, irq}, 8'h01);
        irq_clear = 8'h01;
        tick(1);
        irq_clear = 8'h00;
        check("pend0_cleared", irq_pending & 8'h01, 8'h00);

        // Pin 1 debounce with L=5: 4-cycle glitch rejected, 5-cycle pulse accepted.
        cfg_filt_en = 8'h02; cfg_filt_len = 4'd5;
        pad_raw[1] = 1'b1;
        tick(4);
        pad_raw[1] = 1'b0;
        tick(10);
        check("pin1_glitch", pin_value & 8'h02, 8'h00);
        pad_raw[1] = 1'b1;
        tick(6);
        check("pin1_cycle6", pin_value & 8'h02, 8'h00);
        tick(1);
        check("pin1_cycle7", pin_value & 8'h02, 8'h02);

        // Pin 2 fall: clear coinciding with set loses; a lone clear then wins.
        cfg_irq_fall = 8'h04;
        pad_raw[2] = 1'b1;
        tick(6);
        check("pin2_high", pin_value & 8'h04, 8'h04);
        pad_raw[2] = 1'b0;
        tick(3);
        check("pin2_fell", pin_value & 8'h04, 8'h00);
        irq_clear = 8'h04;
        tick(1);
        check("pend2_set_wins", irq_pending & 8'h04, 8'h04);
        tick(1);
        irq_clear = 8'h00;
        check("pend2_cleared", irq_pending & 8'h04, 8'h00);
        check("irq_low", {7'b0, irq}, 8'h00);

        // Pin 3: dropping ie decays the pin to 0 without recording the fall.
        cfg_irq_rise = 8'h09; cfg_irq_fall = 8'h0C;
        pad_raw[3] = 1'b1;
        tick(4);
        check("pend3_rise", irq_pending & 8'h08, 8'h08);
        irq_clear = 8'h08;
        tick(1);
        irq_clear = 8'h00;
        cfg_ie = 8'hF7;
        tick(8);
        check("pin3_decayed", pin_value & 8'h08, 8'h00);
        check("pend3_masked", irq_pending & 8'h08, 8'h00);
        cfg_ie = 8'hFF;
        tick(6);

        // Pin 5: filter enabled with length 0 acts as length 1.
        cfg_filt_en = 8'h22; cfg_filt_len = 4'd0;
        pad_raw[5] = 1'b1;
        tick(2);
        check("pin5_early", pin_value & 8'h20, 8'h00);
        tick(1);
        check("pin5_len0", pin_value & 8'h20, 8'h20);

        // Pin 6: shortening the length below the running count flips on the next cycle.
        cfg_filt_en = 8'h62; cfg_filt_len = 4'd8;
        pad_raw[6] = 1'b1;
        tick(7);
        check("pin6_counting", pin_value & 8'h40, 8'h00);
        cfg_filt_len = 4'd3;
        tick(1);
        check("pin6_shortened", pin_value & 8'h40, 8'h40);

        // Pin 4: reset mid-count, then a full count from scratch.
        cfg_filt_en = 8'h72; cfg_filt_len = 4'd8;
        pad_raw[4] = 1'b1;
        tick(6);
        check("pin4_midcount", pin_value & 8'h10, 8'h00);
        reset = 1'b1;
        tick(1);
        check("rst2_cell_o", cell_o, 8'h00);
        check("rst2_cell_oe", cell_oe, 8'h00);
        check("rst2_cell_ie", cell_ie, 8'h00);
        check("rst2_pin_value", pin_value, 8'h00);
        check("rst2_irq_pending", irq_pending, 8'h00);
        check("rst2_irq", {7'b0, irq}, 8'h00);
        reset = 1'b0;
        tick(10);
        check("pin4_fresh_early", pin_value & 8'h10, 8'h00);
        tick(1);
        check("pin4_fresh_done", pin_value & 8'h10, 8'h10);

        tick(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
